beh_shifter_param: RTL and testbench

Parametrised behavioural delay line for the tutorial datapath series: a WIDTH-bit, DEPTH-stage register chain with per-stage valid bits, selectable shift/rotate/hold/clear modes, a runtime-selectable output tap and an occupancy counter. It is the general successor to the fixed 8-bit, 4-stage shifter. It sits between a producer that issues words with a valid strobe and a consumer that needs a programmable delay or a circular buffer.

---
 rtl/beh_shifter_param.sv | 136 +++++++++++++
 tb/tb_beh_shifter_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/beh_shifter_param.sv
// beh_shifter_param: parametrised delay line / circular buffer.
//
// A WIDTH-bit, DEPTH-stage register chain with a valid bit per stage. The chain
// can shift in new words, rotate its contents, hold, or clear. A runtime tap
// selects which stage drives the output, and a counter tracks how many stages
// hold valid words.
//
// Parameters:
//   WIDTH  data word width (>= 1)
//   DEPTH  number of register stages (>= 2)
//   TAP_W  width of tap and fill (derived, do not override)
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       asynchronous active-low reset, clears all state
//   en        global enable, 0 holds every register regardless of mode
//   mode      00 shift-in, 01 rotate, 10 hold, 11 synchronous clear
//   din       word entering stage 1 in shift mode
//   din_vld   valid tag for din
//   tap       output stage select 1..DEPTH (0 or >DEPTH selects DEPTH)
//   qout      data of the selected stage
//   qout_vld  valid bit of the selected stage
//   fill      number of stages holding valid data, 0..DEPTH
//   full      fill == DEPTH
module beh_shifter_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAP_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    input  logic [TAP_W-1:0] tap,
    output logic [WIDTH-1:0] qout,
    output logic             qout_vld,
    output logic [TAP_W-1:0] fill,
    output logic             full
);

    localparam logic [1:0] ModeShift  = 2'b00;
    localparam logic [1:0] ModeRotate = 2'b01;
    localparam logic [1:0] ModeHold   = 2'b10;
    localparam logic [1:0] ModeClear  = 2'b11;

    // Index 0 is stage 1 (input end), index DEPTH-1 is stage DEPTH (oldest).
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [TAP_W-1:0] fill_q;
    logic [TAP_W-1:0] fill_d;
    logic [TAP_W-1:0] tap_sel;

    // Next-state logic.
    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        fill_d  = fill_q;
        if (en) begin
            case (mode)
                ModeShift: begin
                    stage_d[0] = din;
                    vld_d[0]   = din_vld;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        stage_d[i] = stage_q[i-1];
                        vld_d[i]   = vld_q[i-1];
                    end
                    // fill >= vld[DEPTH] always holds, so this never underflows,
                    // and a full chain with din_vld=1 loses one word as it gains one.
                    fill_d = fill_q + TAP_W'(din_vld) - TAP_W'(vld_q[DEPTH-1]);
                end
                ModeRotate: begin
                    stage_d[0] = stage_q[DEPTH-1];
                    vld_d[0]   = vld_q[DEPTH-1];
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        stage_d[i] = stage_q[i-1];
                        vld_d[i]   = vld_q[i-1];
                    end
                end
                ModeHold: begin
                end
                ModeClear: begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        stage_d[i] = '0;
                    end
                    vld_d  = '0;
                    fill_d = '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
            vld_q  <= '0;
            fill_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_d[i];
            end
            vld_q  <= vld_d;
            fill_q <= fill_d;
        end
    end

    // Output tap: out-of-range selects clamp to the last stage.
    always_comb begin
        tap_sel = tap;
        if (tap == '0 || tap > TAP_W'(DEPTH)) begin
            tap_sel = TAP_W'(DEPTH);
        end
    end

    always_comb begin
        qout     = stage_q[DEPTH-1];
        qout_vld = vld_q[DEPTH-1];
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (tap_sel == TAP_W'(i + 1)) begin
                qout     = stage_q[i];
                qout_vld = vld_q[i];
            end
        end
    end

    assign fill = fill_q;
    assign full = (fill_q == TAP_W'(DEPTH));

endmodule

// File: tb/tb_beh_shifter_param.sv
// Directed bench for beh_shifter_param: a WIDTH=8/DEPTH=4 instance for the
// main behaviour and a WIDTH=16/DEPTH=7 instance for the long-latency case.
module tb_beh_shifter_param;

    logic        clk;
    logic        rst;

    logic        en;
    logic [1:0]  mode;
    logic [7:0]  din;
    logic        din_vld;
    logic [2:0]  tap;
    logic [7:0]  qout;
    logic        qout_vld;
    logic [2:0]  fill;
    logic        full;

    logic        en2;
    logic [1:0]  mode2;
    logic [15:0] din2;
    logic        din_vld2;
    logic [2:0]  tap2;
    logic [15:0] qout2;
    logic        qout_vld2;
    logic [2:0]  fill2;
    logic        full2;

    int checks;
    int errors;

    beh_shifter_param #(
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .din     (din),
        .din_vld (din_vld),
        .tap     (tap),
        .qout    (qout),
        .qout_vld(qout_vld),
        .fill    (fill),
        .full    (full)
    );

    beh_shifter_param #(
        .WIDTH(16),
        .DEPTH(7)
    ) dut7 (
        .clk     (clk),
        .rst     (rst),
        .en      (en2),
        .mode    (mode2),
        .din     (din2),
        .din_vld (din_vld2),
        .tap     (tap2),
        .qout    (qout2),
        .qout_vld(qout_vld2),
        .fill    (fill2),
        .full    (full2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift(input logic [7:0] d, input logic v);
        mode    = 2'b00;
        din     = d;
        din_vld = v;
        tick();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        en       = 1'b1;
        mode     = 2'b00;
        din      = 8'h00;
        din_vld  = 1'b0;
        tap      = 3'd4;
        en2      = 1'b0;
        mode2    = 2'b00;
        din2     = 16'h0000;
        din_vld2 = 1'b0;
        tap2     = 3'd7;

        // Reset held with live inputs and clocking.
        for (int i = 0; i < 4; i++) begin
            din     = 8'($urandom);
            din_vld = 1'b1;
            tick();
        end
        chk("rst_qout", 32'(qout), 32'h00);
        chk("rst_qout_vld", 32'(qout_vld), 32'h0);
        chk("rst_fill", 32'(fill), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        rst = 1'b1;

        // Empty with din_vld=0 stays empty.
        shift(8'h77, 1'b0);
        chk("empty_fill", 32'(fill), 32'h0);

        // Latency at tap 4.
        shift(8'h11, 1'b1);
        chk("lat_e1_vld", 32'(qout_vld), 32'h0);
        shift(8'h22, 1'b1);
        shift(8'h33, 1'b1);
        chk("lat_e3_vld", 32'(qout_vld), 32'h0);
        chk("lat_e3_fill", 32'(fill), 32'h3);
        shift(8'h44, 1'b1);
        chk("lat_e4_qout", 32'(qout), 32'h11);
        chk("lat_e4_vld", 32'(qout_vld), 32'h1);
        chk("lat_e4_fill", 32'(fill), 32'h4);
        chk("lat_e4_full", 32'(full), 32'h1);
        tap = 3'd2;
        #1;
        chk("tap2_qout", 32'(qout), 32'h33);
        tap = 3'd1;
        #1;
        chk("tap1_qout", 32'(qout), 32'h44);
        tap = 3'd4;

        // Overflow then drain.
        shift(8'h55, 1'b1);
        chk("ovf_qout", 32'(qout), 32'h22);
        chk("ovf_fill", 32'(fill), 32'h4);
        shift(8'h00, 1'b0);
        chk("drain1_fill", 32'(fill), 32'h3);
        shift(8'h00, 1'b0);
        chk("drain2_fill", 32'(fill), 32'h2);
        shift(8'h00, 1'b0);
        chk("drain3_fill", 32'(fill), 32'h1);
        chk("drain3_vld", 32'(qout_vld), 32'h1);
        chk("drain3_qout", 32'(qout), 32'h55);
        shift(8'h00, 1'b0);
        chk("drain4_fill", 32'(fill), 32'h0);
        chk("drain4_vld", 32'(qout_vld), 32'h0);
        chk("drain4_full", 32'(full), 32'h0);

        // Load A1..A4: stage1=A4 ... stage4=A1.
        shift(8'hA1, 1'b1);
        shift(8'hA2, 1'b1);
        shift(8'hA3, 1'b1);
        shift(8'hA4, 1'b1);
        chk("load_qout", 32'(qout), 32'hA1);

        // Rotate: stage1 takes stage4, others move down one.
        mode = 2'b01;
        din = 8'hFF;
        din_vld = 1'b0;
        tick();
        chk("rot1_qout", 32'(qout), 32'hA2);
        chk("rot1_fill", 32'(fill), 32'h4);
        din = 8'h5C;
        din_vld = 1'b1;
        tick();
        chk("rot2_qout", 32'(qout), 32'hA3);
        din = 8'h00;
        din_vld = 1'b0;
        tick();
        chk("rot3_qout", 32'(qout), 32'hA4);
        din = 8'hEE;
        din_vld = 1'b1;
        tick();
        chk("rot4_qout", 32'(qout), 32'hA1);
        chk("rot4_vld", 32'(qout_vld), 32'h1);
        chk("rot4_fill", 32'(fill), 32'h4);
        tap = 3'd1;
        #1;
        chk("rot4_tap1", 32'(qout), 32'hA4);
        tap = 3'd4;

        // Enable gates clear; hold changes nothing.
        en = 1'b0;
        mode = 2'b11;
        tick();
        chk("en0_clr_qout", 32'(qout), 32'hA1);
        chk("en0_clr_fill", 32'(fill), 32'h4);
        en = 1'b1;
        mode = 2'b10;
        din = 8'h99;
        din_vld = 1'b1;
        tick();
        chk("hold_qout", 32'(qout), 32'hA1);
        chk("hold_fill", 32'(fill), 32'h4);
        en = 1'b0;
        mode = 2'b00;
        tick();
        chk("en0_shift_qout", 32'(qout), 32'hA1);
        en = 1'b1;

        // Tap clamping.
        mode = 2'b10;
        tap = 3'd0;
        #1;
        chk("tap0_clamp", 32'(qout), 32'hA1);
        tap = 3'd7;
        #1;
        chk("tap7_clamp", 32'(qout), 32'hA1);
        tap = 3'd5;
        #1;
        chk("tap5_clamp", 32'(qout), 32'hA1);
        tap = 3'd3;
        #1;
        chk("tap3_qout", 32'(qout), 32'hA2);
        tap = 3'd4;

        // Synchronous clear.
        mode = 2'b11;
        tick();
        chk("clr_qout", 32'(qout), 32'h00);
        chk("clr_vld", 32'(qout_vld), 32'h0);
        chk("clr_fill", 32'(fill), 32'h0);
        chk("clr_full", 32'(full), 32'h0);

        // Asynchronous reset mid-cycle.
        tap = 3'd1;
        shift(8'h5A, 1'b1);
        chk("pre_arst_qout", 32'(qout), 32'h5A);
        chk("pre_arst_fill", 32'(fill), 32'h1);
        din = 8'h6B;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_qout", 32'(qout), 32'h00);
        chk("arst_vld", 32'(qout_vld), 32'h0);
        chk("arst_fill", 32'(fill), 32'h0);
        tick();
        chk("arst_edge_fill", 32'(fill), 32'h0);
        rst = 1'b1;
        tap = 3'd4;

        // DEPTH=7, WIDTH=16: word appears at tap 7 after 7 edges.
        en2 = 1'b1;
        mode2 = 2'b00;
        tap2 = 3'd7;
        din2 = 16'hBEEF;
        din_vld2 = 1'b1;
        tick();
        din2 = 16'h0000;
        din_vld2 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("d7_e6_vld", 32'(qout_vld2), 32'h0);
        tick();
        chk("d7_e7_qout", 32'(qout2), 32'hBEEF);
        chk("d7_e7_vld", 32'(qout_vld2), 32'h1);
        chk("d7_e7_fill", 32'(fill2), 32'h1);
        tap2 = 3'd0;
        #1;
        chk("d7_tap0_clamp", 32'(qout2), 32'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
